// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between decode, the multiply/divide unit and the regfile write port.
// Master is the issue side; slave is the unit.
interface muldiv_unit_if #(parameter int WIDTH = 16);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [2:0]       rd_in;
   logic             flush;
   logic             busy;
   logic             wr;
   logic [2:0]       rd_out;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;

   modport master (
      output start, op, rs_val, rt_val, rd_in, flush,
      input  busy, wr, rd_out, result, div_by_zero
   );

   modport slave (
      input  start, op, rs_val, rt_val, rd_in, flush,
      output busy, wr, rd_out, result, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit feeding the regfile write port.
// 17 cycles start-to-wr (1 for divide by zero); busy stalls issue, start is ignored unless IDLE.
module muldiv_unit #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_unit_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_nxt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q, acc_nxt;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         rd_q, rd_out_q;
   logic [WIDTH-1:0]   result_q;
   logic               dbz_q;
   logic [WIDTH:0]     mul_sum, rem_shift, rem_diff;
   logic               accept, div_zero, last_step;

   assign accept    = (state == IDLE) && bus.start && !bus.flush;
   assign div_zero  = bus.op[1] && (bus.rt_val == '0);
   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
      rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
      rem_diff  = rem_shift - {1'b0, opnd_q};
      if (!op_q[1])
         acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
      else if (!rem_diff[WIDTH])
         acc_nxt = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
         acc_nxt = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
         CALC: begin
            if (bus.flush)     state_nxt = IDLE;
            else if (last_step) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q     <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else if (accept) begin
         op_q  <= bus.op;
         rd_q  <= bus.rd_in;
         cnt_q <= '0;
         if (bus.op[1]) begin
            opnd_q <= bus.rt_val;
            acc_q  <= {{WIDTH{1'b0}}, bus.rs_val};
         end else begin
            opnd_q <= bus.rs_val;
            acc_q  <= {{WIDTH{1'b0}}, bus.rt_val};
         end
         dbz_q <= div_zero;
         if (div_zero) begin
            result_q <= bus.op[0] ? bus.rs_val : {WIDTH{1'b1}};
            rd_out_q <= bus.rd_in;
         end
      end else if (state == CALC && !bus.flush) begin
         acc_q <= acc_nxt;
         cnt_q <= cnt_q + CNT_W'(1);
         if (last_step) begin
            result_q <= op_q[0] ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
            rd_out_q <= rd_q;
         end
      end
   end

   // A flush arriving in DONE kills the write strobe in the same cycle
   assign bus.wr          = (state == DONE) && !bus.flush;
   assign bus.div_by_zero = bus.wr && dbz_q;
   assign bus.busy        = (state != IDLE);
   assign bus.rd_out      = rd_out_q;
   assign bus.result      = result_q;
endmodule
